// File: rtl/maxpool_pkg.sv
// Shared CNN geometry, pooling defaults and the pooling FSM state type.
package maxpool_pkg;

    localparam int DATA_WIDTH          = 8;
    localparam int CONV_OFMAP_SIZE     = 24;
    localparam int POOL_SIZE_DEFAULT   = 2;
    localparam int POOL_STRIDE_DEFAULT = 2;

    // Trailing rows/columns that cannot hold a full window are dropped (floor).
    localparam int POOL_OFMAP_SIZE =
        (CONV_OFMAP_SIZE - POOL_SIZE_DEFAULT) / POOL_STRIDE_DEFAULT + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } pool_state_e;

endpackage

// File: rtl/maxpool_max_window.sv
// Combinational unsigned maximum over one flattened pooling window.
module max_window
    import maxpool_pkg::*;
#(
    parameter int N  = POOL_SIZE_DEFAULT * POOL_SIZE_DEFAULT,
    parameter int DW = DATA_WIDTH
) (
    input  logic [DW-1:0] win_i [0:N-1],
    output logic [DW-1:0] max_o
);

    // Running maximum; a tie keeps the earlier value, which equals the later one.
    always_comb begin
        // NOTE: seed the result before the loop so every path assigns it and no latch is inferred.
        max_o = win_i[0];
        for (int k = 1; k < N; k++) begin
            if (win_i[k] > max_o) max_o = win_i[k];
        end
    end

endmodule

// File: rtl/maxpool.sv
// Max-pooling engine: walks the output grid one element per enabled cycle.
module maxpool
    import maxpool_pkg::*;
#(
    parameter int POOL_SIZE   = POOL_SIZE_DEFAULT,
    parameter int POOL_STRIDE = POOL_STRIDE_DEFAULT,
    localparam int POOL_OUT   = (CONV_OFMAP_SIZE - POOL_SIZE) / POOL_STRIDE + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] pool_ifmap [0:CONV_OFMAP_SIZE-1][0:CONV_OFMAP_SIZE-1],
    output logic [DATA_WIDTH-1:0] pool_ofmap [0:POOL_OUT-1][0:POOL_OUT-1],
    output logic                  pool_done
);

    localparam int CW  = (POOL_OUT > 1) ? $clog2(POOL_OUT) : 1;
    localparam int IW  = (CONV_OFMAP_SIZE > 1) ? $clog2(CONV_OFMAP_SIZE) : 1;
    localparam int WIN = POOL_SIZE * POOL_SIZE;
    localparam logic [CW-1:0] LAST = CW'(POOL_OUT - 1);

    pool_state_e         state_q, state_d;
    logic [CW-1:0]       row_q, row_d;
    logic [CW-1:0]       col_q, col_d;
    logic                wr_en;
    logic [DATA_WIDTH-1:0] win     [0:WIN-1];
    logic [DATA_WIDTH-1:0] win_max;

    // Gather the input window addressed by the current output (row, col).
    always_comb begin
        logic [IW-1:0] r_idx;
        logic [IW-1:0] c_idx;
        for (int i = 0; i < POOL_SIZE; i++) begin
            for (int j = 0; j < POOL_SIZE; j++) begin
                r_idx = IW'(int'(row_q) * POOL_STRIDE + i);
                c_idx = IW'(int'(col_q) * POOL_STRIDE + j);
                win[i*POOL_SIZE+j] = pool_ifmap[r_idx][c_idx];
            end
        end
    end

    max_window #(
        .N  (WIN),
        .DW (DATA_WIDTH)
    ) u_max_window (
        .win_i (win),
        .max_o (win_max)
    );

    // State and position counters; reset aborts any run in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    // Next state and raster-order advance of (row, col); en low pauses a run.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_d = S_RUN;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            S_RUN: begin
                if (en) begin
                    if (col_q == LAST) begin
                        col_d = '0;
                        if (row_q == LAST) begin
                            row_d   = '0;
                            state_d = S_DONE;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (!en) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode: write strobe while running, done flag while parked in DONE.
    always_comb begin
        wr_en     = (state_q == S_RUN) && en;
        pool_done = (state_q == S_DONE);
    end

    // Result array: one element written per active cycle, held otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: this array is a visible output that must read as zero after reset, so it is reset element by element rather than left as uninitialised storage.
            for (int r = 0; r < POOL_OUT; r++) begin
                for (int c = 0; c < POOL_OUT; c++) begin
                    pool_ofmap[r][c] <= '0;
                end
            end
        end else if (wr_en) begin
            pool_ofmap[row_q][col_q] <= win_max;
        end
    end

endmodule

// File: tb/tb_maxpool.sv
// Self-checking bench for maxpool against an array-level reference model.
module tb_maxpool;
    import maxpool_pkg::*;

    localparam int C  = CONV_OFMAP_SIZE;
    localparam int PS = POOL_SIZE_DEFAULT;
    localparam int ST = POOL_STRIDE_DEFAULT;
    localparam int P  = (C - PS) / ST + 1;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  en;
    logic [DATA_WIDTH-1:0] ifmap [0:C-1][0:C-1];
    logic [DATA_WIDTH-1:0] ofmap [0:P-1][0:P-1];
    logic                  done;

    int exp_map  [0:P-1][0:P-1];
    int prev_map [0:P-1][0:P-1];
    int n_checks = 0;
    int n_fail   = 0;

    maxpool dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .pool_ifmap (ifmap),
        .pool_ofmap (ofmap),
        .pool_done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain max over each stride-spaced window of the input map.
    task automatic model();
        for (int r = 0; r < P; r++) begin
            for (int c = 0; c < P; c++) begin
                int m;
                m = 0;
                for (int i = 0; i < PS; i++)
                    for (int j = 0; j < PS; j++)
                        if (int'(ifmap[r*ST+i][c*ST+j]) > m) m = int'(ifmap[r*ST+i][c*ST+j]);
                exp_map[r][c] = m;
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int r = 0; r < P; r++)
            for (int c = 0; c < P; c++)
                check($sformatf("%s[%0d][%0d]", tag, r, c), int'(ofmap[r][c]), exp_map[r][c]);
    endtask

    task automatic fill_const(input int v);
        for (int r = 0; r < C; r++)
            for (int c = 0; c < C; c++)
                ifmap[r][c] = DATA_WIDTH'(v);
    endtask

    task automatic fill_random();
        for (int r = 0; r < C; r++)
            for (int c = 0; c < C; c++)
                ifmap[r][c] = DATA_WIDTH'($urandom);
    endtask

    // Drive one run from IDLE. Optional pause after pause_at writes, optional
    // reset pulse after reset_at writes. Returns edges counted from the en-sampling edge.
    task automatic do_run(input int pause_at, input int pause_len, input int reset_at,
                          output int edges);
        int writes;
        edges  = 0;
        writes = 0;
        en = 1'b1;
        step();
        edges++;
        while (!done && edges < 2000) begin
            if (writes == reset_at) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
                en    = 1'b0;
                return;
            end
            if (writes == pause_at) begin
                en = 1'b0;
                for (int k = 0; k < pause_len; k++) begin
                    step();
                    edges++;
                    check("pause_done_low", int'(done), 0);
                end
                check("pause_hold_next", int'(ofmap[pause_at / P][pause_at % P]),
                      prev_map[pause_at / P][pause_at % P]);
                check("pause_last_written", int'(ofmap[(pause_at-1) / P][(pause_at-1) % P]),
                      exp_map[(pause_at-1) / P][(pause_at-1) % P]);
                en = 1'b1;
            end
            step();
            edges++;
            writes++;
        end
        check("run_timeout", int'(edges >= 2000), 0);
    endtask

    task automatic finish_run();
        en = 1'b0;
        step();
        check("done_drop", int'(done), 0);
    endtask

    task automatic plain_run(input string tag);
        int edges;
        model();
        do_run(-1, 0, -1, edges);
        check({tag, "_latency"}, edges, P*P + 1);
        check_all(tag);
        finish_run();
    endtask

    initial begin
        int edges;
        reset = 1'b1;
        en    = 1'b1;
        fill_const(9);
        step();
        step();
        check("reset_done", int'(done), 0);
        for (int k = 0; k < P*P; k++) exp_map[k / P][k % P] = 0;
        check_all("reset_ofmap");
        reset = 1'b0;
        en    = 1'b0;
        step();
        step();
        check("idle_no_start", int'(done), 0);
        check("idle_ofmap", int'(ofmap[0][0]), 0);

        for (int r = 0; r < C; r++)
            for (int c = 0; c < C; c++)
                ifmap[r][c] = DATA_WIDTH'((r + c) % 256);
        plain_run("ramp");
        check("ramp_formula", int'(ofmap[3][5]), (2*3 + 2*5 + 2) % 256);

        fill_const(0);
        ifmap[5][7] = 8'd200;
        plain_run("hot");

        fill_const(255);
        plain_run("all255");
        fill_const(17);
        plain_run("all17");

        for (int n = 0; n < 3; n++) begin
            fill_random();
            plain_run($sformatf("rand%0d", n));
        end

        // Pause after 50 outputs; unwritten entries must still show the previous run.
        prev_map = exp_map;
        for (int r = 0; r < C; r++)
            for (int c = 0; c < C; c++)
                ifmap[r][c] = DATA_WIDTH'((r + c) % 256);
        model();
        do_run(50, 10, -1, edges);
        check("pause_latency", edges, P*P + 1 + 10);
        check_all("pause");
        finish_run();

        // Reset after 100 outputs with en still high; everything clears.
        fill_random();
        do_run(-1, 0, 100, edges);
        check("midreset_done", int'(done), 0);
        for (int k = 0; k < P*P; k++) exp_map[k / P][k % P] = 0;
        check_all("midreset_zero");
        step();
        step();
        step();
        check("midreset_idle", int'(done), 0);
        check("midreset_stay0", int'(ofmap[0][0]), 0);
        plain_run("rerun");

        // Hold en high in DONE: no restart, outputs stable.
        fill_random();
        model();
        do_run(-1, 0, -1, edges);
        check("hold_latency", edges, P*P + 1);
        for (int k = 0; k < 20; k++) begin
            step();
            check("hold_done", int'(done), 1);
        end
        check_all("hold");
        finish_run();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
